// File: rtl/d_ip_timer_pkg.sv
// Shared constants and types for the multi-channel timer: register offsets,
// CTRL bit layout and the per-channel control struct.
package d_ip_timer_pkg;

  localparam logic [2:0] OFS_CTRL   = 3'd0;
  localparam logic [2:0] OFS_STATUS = 3'd1;
  localparam logic [2:0] OFS_CMP_LO = 3'd2;
  localparam logic [2:0] OFS_CMP_HI = 3'd3;
  localparam logic [2:0] OFS_CNT_LO = 3'd4;
  localparam logic [2:0] OFS_CNT_HI = 3'd5;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_MODE_BIT   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_PS_LSB     = 4;
  localparam int unsigned CTRL_PS_MSB     = 6;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } mode_e;

  typedef struct packed {
    logic [2:0] ps;
    logic       irq_en;
    mode_e      mode;
    logic       en;
  } ctrl_t;

  // Reserved bits 3 and 7 read back as 0.
  function automatic logic [7:0] ctrl_to_byte(ctrl_t c);
    logic [7:0] b;
    b                            = '0;
    b[CTRL_EN_BIT]               = c.en;
    b[CTRL_MODE_BIT]             = c.mode;
    b[CTRL_IRQ_EN_BIT]           = c.irq_en;
    b[CTRL_PS_MSB:CTRL_PS_LSB]   = c.ps;
    return b;
  endfunction

  // Low PS bits of the shared prescaler that must all be ones for a tick.
  function automatic logic [7:0] ps_mask(logic [2:0] ps);
    return ~(8'hFF << ps);
  endfunction

endpackage

// File: rtl/d_ip_timer_mc_if.sv
// Byte-wide peripheral register port of the multi-channel timer.
interface d_ip_timer_mc_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
);

  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              mod_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output mod_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  mod_en,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/d_ip_timer_ch.sv
// One timer channel: CTRL, CMP staging and commit, counter with coherent
// high-byte shadow, match flag and interrupt.
module d_ip_timer_ch
  import d_ip_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       wr_ctrl_i,
  input  logic       wr_status_i,
  input  logic       wr_cmp_lo_i,
  input  logic       wr_cmp_hi_i,
  input  logic       rd_cnt_lo_i,
  input  logic [2:0] ofs_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic [2:0] ps_o,
  output logic       irq_o
);

  ctrl_t              ctrl_q, ctrl_d;
  logic [7:0]         stage_q, stage_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-9:0]   shadow_q, shadow_d;
  logic               flag_q, flag_d;
  logic               step;
  logic               match;

  assign step  = ctrl_q.en & tick_i;
  assign match = step & (cnt_q == cmp_q);

  always_comb begin
    ctrl_d   = ctrl_q;
    stage_d  = stage_q;
    cmp_d    = cmp_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    flag_d   = flag_q;

    if (step) begin
      cnt_d = match ? '0 : cnt_q + CNT_W'(1);
    end
    if (match && (ctrl_q.mode == ONESHOT)) begin
      ctrl_d.en = 1'b0;
    end

    // A CTRL write overrides the one-shot auto-disable on the same edge.
    if (wr_ctrl_i) begin
      ctrl_d.en     = wdata_i[CTRL_EN_BIT];
      ctrl_d.mode   = mode_e'(wdata_i[CTRL_MODE_BIT]);
      ctrl_d.irq_en = wdata_i[CTRL_IRQ_EN_BIT];
      ctrl_d.ps     = wdata_i[CTRL_PS_MSB:CTRL_PS_LSB];
      if (wdata_i[CTRL_EN_BIT] && !ctrl_q.en) begin
        cnt_d = '0;
      end
    end

    if (wr_status_i && wdata_i[0]) begin
      flag_d = 1'b0;
    end
    if (match) begin
      flag_d = 1'b1;
    end

    if (wr_cmp_lo_i) begin
      stage_d = wdata_i;
    end
    if (wr_cmp_hi_i) begin
      cmp_d = CNT_W'({wdata_i, stage_q});
    end

    if (rd_cnt_lo_i) begin
      shadow_d = cnt_q[CNT_W-1:8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      stage_q  <= '0;
      cmp_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      stage_q  <= stage_d;
      cmp_q    <= cmp_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (ofs_i)
      OFS_CTRL:   rdata_o = ctrl_to_byte(ctrl_q);
      OFS_STATUS: rdata_o = {6'b0, ctrl_q.en, flag_q};
      OFS_CMP_LO: rdata_o = stage_q;
      OFS_CMP_HI: rdata_o = 8'(cmp_q[CNT_W-1:8]);
      OFS_CNT_LO: rdata_o = cnt_q[7:0];
      OFS_CNT_HI: rdata_o = 8'(shadow_q);
      default:    rdata_o = '0;
    endcase
  end

  assign ps_o  = ctrl_q.ps;
  assign irq_o = flag_q & ctrl_q.irq_en;

endmodule

// File: rtl/d_ip_timer_mc.sv
// Multi-channel timer top: shared prescaler, address decode, channel array
// and registered read-data mux.
module d_ip_timer_mc
  import d_ip_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  d_ip_timer_mc_if.slave    bus,
  output logic [NUM_CH-1:0] irq_o,
  output logic              irq_any_o
);

  localparam int unsigned ChW = ADDR_W - 3;

  logic [7:0]        pre_q;
  logic [ChW-1:0]    ch_idx;
  logic [2:0]        ofs;
  logic [7:0]        ch_rd [NUM_CH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign ch_idx = bus.addr[ADDR_W-1:3];
  assign ofs    = bus.addr[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic       hit;
    logic       tick;
    logic [2:0] ps;

    assign hit  = bus.mod_en & (ch_idx == ChW'(i));
    assign tick = (pre_q & ps_mask(ps)) == ps_mask(ps);

    d_ip_timer_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .wr_ctrl_i   (hit & bus.wr_en & (ofs == OFS_CTRL)),
      .wr_status_i (hit & bus.wr_en & (ofs == OFS_STATUS)),
      .wr_cmp_lo_i (hit & bus.wr_en & (ofs == OFS_CMP_LO)),
      .wr_cmp_hi_i (hit & bus.wr_en & (ofs == OFS_CMP_HI)),
      .rd_cnt_lo_i (hit & ~bus.wr_en & (ofs == OFS_CNT_LO)),
      .ofs_i       (ofs),
      .wdata_i     (bus.wdata),
      .rdata_o     (ch_rd[i]),
      .ps_o        (ps),
      .irq_o       (irq_o[i])
    );
  end

  // Channel indices beyond NUM_CH never match and so read 0.
  always_comb begin
    rdata_d = '0;
    if (bus.mod_en && !bus.wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == ChW'(i)) begin
          rdata_d = ch_rd[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_d_ip_timer_mc.sv
// Self-checking bench for d_ip_timer_mc: register reads go through a scoreboard
// queue and are compared one cycle after issue.
module tb_d_ip_timer_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic       irq_any;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  logic [7:0] v;
  int         k;
  logic       found;

  d_ip_timer_mc_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  d_ip_timer_mc #(
    .NUM_CH(4),
    .CNT_W (16),
    .ADDR_W(6),
    .DATA_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .irq_o    (irq),
    .irq_any_o(irq_any)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr   = a;
    bus.wdata  = d;
    bus.wr_en  = 1'b1;
    bus.mod_en = 1'b1;
    @(posedge clk);
    #1;
    bus.mod_en = 1'b0;
    bus.wr_en  = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e, input string tag);
    @(negedge clk);
    bus.addr   = a;
    bus.wr_en  = 1'b0;
    bus.mod_en = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    bus.mod_en = 1'b0;
    check_eq(tag_q.pop_front(), {24'b0, bus.rdata}, {24'b0, exp_q.pop_front()});
  endtask

  task automatic rd_raw(input logic [5:0] a, output logic [7:0] val);
    @(negedge clk);
    bus.addr   = a;
    bus.wr_en  = 1'b0;
    bus.mod_en = 1'b1;
    @(posedge clk);
    #1;
    bus.mod_en = 1'b0;
    val = bus.rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.wr_en  = 1'b0;
    bus.mod_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdata", {24'b0, bus.rdata}, 32'h0);
    check_eq("rst_irq", {28'b0, irq}, 32'h0);
    check_eq("rst_irq_any", {31'b0, irq_any}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(6'h00, 8'h00, "rst_ctrl0");
    rd(6'h04, 8'h00, "rst_cnt0");

    // Periodic ch0, PS=0, CMP=4, IRQ_EN: match every 5 cycles
    wr(6'h02, 8'h04);
    wr(6'h03, 8'h00);
    wr(6'h00, 8'h05);
    for (int i = 1; i <= 6; i++) begin
      rd(6'h01, (i == 6) ? 8'h03 : 8'h02, "per_status");
      check_eq("per_irq", {31'b0, irq[0]}, (i >= 5) ? 32'h1 : 32'h0);
    end
    wr(6'h01, 8'h01);
    check_eq("per_w1c_irq", {31'b0, irq[0]}, 32'h0);
    for (int i = 8; i <= 11; i++) begin
      rd(6'h01, (i == 11) ? 8'h03 : 8'h02, "per_status2");
      check_eq("per_irq2", {31'b0, irq[0]}, (i >= 10) ? 32'h1 : 32'h0);
    end
    check_eq("per_irq_any", {31'b0, irq_any}, 32'h1);

    // Asynchronous reset mid-run
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_irq", {28'b0, irq}, 32'h0);
    check_eq("mid_rst_irq_any", {31'b0, irq_any}, 32'h0);
    check_eq("mid_rst_rdata", {24'b0, bus.rdata}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(6'h00, 8'h00, "mid_rst_ctrl");
    rd(6'h01, 8'h00, "mid_rst_status");
    rd(6'h02, 8'h00, "mid_rst_cmp_lo");
    rd(6'h03, 8'h00, "mid_rst_cmp_hi");
    idle(10);
    rd(6'h04, 8'h00, "mid_rst_cnt_hold");

    // One-shot ch1, PS=2, CMP=2: third tick 9..12 cycles after enable
    wr(6'h0A, 8'h02);
    wr(6'h0B, 8'h00);
    wr(6'h08, 8'h23);
    found = 1'b0;
    k     = 0;
    v     = '0;
    for (int i = 1; i <= 20 && !found; i++) begin
      rd_raw(6'h09, v);
      if (v[0]) begin
        found = 1'b1;
        k     = i;
      end
    end
    check_eq("os_flag_seen", {31'b0, found}, 32'h1);
    check_eq("os_status", {24'b0, v}, 32'h01);
    check_eq("os_latency_in_9_12", {31'b0, ((k - 1) >= 9) && ((k - 1) <= 12)}, 32'h1);
    rd(6'h08, 8'h22, "os_ctrl_en_cleared");
    rd(6'h0C, 8'h00, "os_cnt_lo");
    rd(6'h0D, 8'h00, "os_cnt_hi");
    check_eq("os_irq_masked", {31'b0, irq[1]}, 32'h0);
    idle(8);
    rd(6'h0C, 8'h00, "os_cnt_hold");

    // Coherent 16-bit counter read on ch2
    wr(6'h12, 8'h00);
    wr(6'h13, 8'h03);
    wr(6'h10, 8'h01);
    idle(9'h1FF);
    rd(6'h14, 8'hFF, "coh_cnt_lo");
    idle(5);
    rd(6'h15, 8'h01, "coh_cnt_hi_shadow");
    rd(6'h13, 8'h03, "coh_cmp_hi");
    rd(6'h12, 8'h00, "coh_cmp_lo");
    wr(6'h10, 8'h00);

    // W1C on a match edge: set wins
    wr(6'h02, 8'h00);
    wr(6'h03, 8'h00);
    wr(6'h00, 8'h01);
    idle(2);
    wr(6'h01, 8'h01);
    rd(6'h01, 8'h03, "race_flag_set_wins");
    rd(6'h04, 8'h00, "race_cnt");
    wr(6'h00, 8'h00);
    rd(6'h01, 8'h01, "race_stopped_status");
    check_eq("race_irq_masked", {31'b0, irq[0]}, 32'h0);

    // Address decode: unmapped channel/offsets read 0, writes ignored
    wr(6'h3E, 8'hFF);
    wr(6'h20, 8'hFF);
    rd(6'h3E, 8'h00, "dec_3e");
    rd(6'h20, 8'h00, "dec_20");
    rd(6'h00, 8'h00, "dec_ch0_ctrl");
    rd(6'h18, 8'h00, "dec_ch3_ctrl");
    rd(6'h1E, 8'h00, "dec_ch3_rsvd");
    rd(6'h06, 8'h00, "dec_ofs6");
    rd(6'h07, 8'h00, "dec_ofs7");
    wr(6'h18, 8'hFF);
    rd(6'h18, 8'h77, "ctrl_reserved_bits");
    wr(6'h18, 8'h00);
    idle(1);
    check_eq("rdata_idle_zero", {24'b0, bus.rdata}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
